// File: rtl/k_dsp_pkg.sv
// Shared K_DSP constants and the weight-memory fill state type.
package k_dsp_pkg;

   localparam int K_DATA_W     = 32;
   localparam int K_WMEM_DEPTH = 3200;
   localparam int K_WMEM_BANKS = 24;

   typedef enum logic {FILL, FULL} wmem_state_t;

endpackage

// File: rtl/k_wmem_wr_ptr.sv
// Sequential write pointer for k_wmem_banked: bank/address walk, fill level
// and the FILL/FULL state machine.
module k_wmem_wr_ptr
   import k_dsp_pkg::*;
#(
   parameter int DEPTH     = K_WMEM_DEPTH,
   parameter int NUM_BANKS = K_WMEM_BANKS,
   parameter int AW        = $clog2(DEPTH),
   parameter int BW        = $clog2(NUM_BANKS),
   parameter int LW        = $clog2(DEPTH*NUM_BANKS+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          restart,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic          full,
   output logic          wr_en,
   output logic [BW-1:0] wr_bank,
   output logic [AW-1:0] wr_addr,
   output logic [LW-1:0] level
);

   wmem_state_t   state_q, state_d;
   logic [BW-1:0] bank_q, bank_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] level_q, level_d;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= FILL;
         bank_q  <= '0;
         addr_q  <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         level_q <= level_d;
      end

   always_comb begin
      state_d  = state_q;
      bank_d   = bank_q;
      addr_d   = addr_q;
      level_d  = level_q;
      wr_ready = (state_q == FILL);
      full     = (state_q == FULL);
      // restart wins over a concurrent write, so the offered word is dropped
      wr_en    = wr_valid && (state_q == FILL) && !restart;
      if (restart) begin
         state_d = FILL;
         bank_d  = '0;
         addr_d  = '0;
         level_d = '0;
      end else if (wr_en) begin
         level_d = level_q + LW'(1);
         if (addr_q == AW'(DEPTH-1)) begin
            addr_d = '0;
            if (bank_q == BW'(NUM_BANKS-1)) begin
               bank_d  = '0;
               state_d = FULL;
            end else begin
               bank_d = bank_q + BW'(1);
            end
         end else begin
            addr_d = addr_q + AW'(1);
         end
      end
   end

   assign wr_bank = bank_q;
   assign wr_addr = addr_q;
   assign level   = level_q;

endmodule

// File: rtl/k_wmem_banked.sv
// Multi-bank weight memory: streamed sequential fill, random banked read.
// Define K_WMEM_OUTREG_EN to add a second read output register (latency 2).
module k_wmem_banked
   import k_dsp_pkg::*;
#(
   parameter int DATA_W    = K_DATA_W,
   parameter int DEPTH     = K_WMEM_DEPTH,
   parameter int NUM_BANKS = K_WMEM_BANKS,
   parameter int AW        = $clog2(DEPTH),
   parameter int BW        = $clog2(NUM_BANKS),
   parameter int LW        = $clog2(DEPTH*NUM_BANKS+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [BW-1:0]     rd_bank,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   output logic              full,
   output logic [LW-1:0]     level
);

   localparam int WORDS = DEPTH * NUM_BANKS;
   localparam int IW    = $clog2(WORDS);
`ifdef K_WMEM_OUTREG_EN
   localparam int STAGES = 2;
`else
   localparam int STAGES = 1;
`endif

   logic              wr_en, rd_oor;
   logic [BW-1:0]     wr_bank;
   logic [AW-1:0]     wr_addr;
   logic [IW-1:0]     wr_idx, rd_idx;
   logic [DATA_W-1:0] mem [WORDS];

   logic [STAGES:1]   vld_pipe;
   logic [STAGES:1]   err_pipe;
   logic [DATA_W-1:0] dat_pipe [STAGES:1];

   k_wmem_wr_ptr #(
      .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS), .AW(AW), .BW(BW), .LW(LW)
   ) u_wr_ptr (
      .clk(clk), .rst(rst), .restart(restart), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .full(full), .wr_en(wr_en),
      .wr_bank(wr_bank), .wr_addr(wr_addr), .level(level)
   );

   // Banks are stored back to back in one flat array; index = bank*DEPTH + addr.
   assign rd_oor = (32'(rd_bank) >= NUM_BANKS) || (32'(rd_addr) >= DEPTH);
   assign wr_idx = IW'(32'(wr_bank) * DEPTH + 32'(wr_addr));
   assign rd_idx = rd_oor ? '0 : IW'(32'(rd_bank) * DEPTH + 32'(rd_addr));

   always_ff @(posedge clk)
      if (wr_en) mem[wr_idx] <= wr_data;

   // Stage 1 samples the array before this edge's write lands (read-old).
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vld_pipe[1] <= 1'b0;
         err_pipe[1] <= 1'b0;
         dat_pipe[1] <= '0;
      end else begin
         vld_pipe[1] <= rd_en;
         if (rd_en) begin
            err_pipe[1] <= rd_oor;
            dat_pipe[1] <= rd_oor ? '0 : mem[rd_idx];
         end
      end

   for (genvar s = 2; s <= STAGES; s++) begin : g_outreg
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            vld_pipe[s] <= 1'b0;
            err_pipe[s] <= 1'b0;
            dat_pipe[s] <= '0;
         end else begin
            vld_pipe[s] <= vld_pipe[s-1];
            if (vld_pipe[s-1]) begin
               err_pipe[s] <= err_pipe[s-1];
               dat_pipe[s] <= dat_pipe[s-1];
            end
         end
   end

   assign rd_valid = vld_pipe[STAGES];
   assign rd_err   = err_pipe[STAGES];
   assign rd_data  = dat_pipe[STAGES];

endmodule

// File: tb/tb_k_wmem_banked.sv
// Bench for k_wmem_banked at DEPTH=4, NUM_BANKS=3. AW is widened to 3 so that
// an out-of-range address (5) can actually be presented on rd_addr.
module tb_k_wmem_banked;

   localparam int DEPTH = 4, NB = 3, AW = 3, BW = 2, LW = 4, DW = 32;
   localparam int WORDS = DEPTH * NB;
`ifdef K_WMEM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst, restart, wr_valid, wr_ready, rd_en, rd_valid, rd_err, full;
   logic [DW-1:0] wr_data, rd_data;
   logic [BW-1:0] rd_bank;
   logic [AW-1:0] rd_addr;
   logic [LW-1:0] level;

   k_wmem_banked #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .AW(AW)) dut (
      .clk(clk), .rst(rst), .restart(restart), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_data(wr_data), .rd_en(rd_en), .rd_bank(rd_bank),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
      .full(full), .level(level)
   );

   always #5 clk = ~clk;

   // Reference model: flat word store filled in order (word index == level),
   // plus a queue of read results tagged with the edge at which they appear.
   typedef struct {int due; logic [31:0] d; bit e; bit k;} rd_t;
   rd_t         rq[$];
   logic [31:0] mem_m [WORDS];
   bit          known [WORDS];
   int          lvl, cnum, n_chk, n_pass;
   bit          exp_v, exp_e, exp_k;
   logic [31:0] exp_d;

   task automatic model_reset();
      lvl = 0; rq.delete(); exp_v = 0; exp_e = 0; exp_k = 1; exp_d = '0;
      for (int i = 0; i < WORDS; i++) known[i] = 0;
   endtask

   task automatic cyc(input bit rs, input bit wv, input logic [31:0] wd,
                      input bit re, input int rb, input int ra);
      rd_t r;
      restart = rs; wr_valid = wv; wr_data = wd; rd_en = re;
      rd_bank = rb[BW-1:0]; rd_addr = ra[AW-1:0];
      if (re) begin
         r.due = cnum + LAT;
         r.e   = (rb >= NB) || (ra >= DEPTH);
         r.d   = r.e ? 32'h0 : mem_m[rb*DEPTH+ra];
         r.k   = r.e || known[rb*DEPTH+ra];
         rq.push_back(r);
      end
      if (rs) lvl = 0;
      else if (wv && lvl < WORDS) begin mem_m[lvl] = wd; known[lvl] = 1; lvl++; end
      @(posedge clk); cnum++;
      exp_v = 0;
      if (rq.size() > 0 && rq[0].due == cnum) begin
         r = rq.pop_front(); exp_v = 1; exp_d = r.d; exp_e = r.e; exp_k = r.k;
      end
      #1;
   endtask

   task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask

   task automatic test_reset();
      rst = 0; restart = 0; wr_valid = 0; wr_data = 0; rd_en = 0; rd_bank = 0; rd_addr = 0;
      #1 rst = 1; model_reset();
      #2;
      n_chk++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready); else n_pass++;
      n_chk++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
      n_chk++; if (level !== '0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
      n_chk++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) $display("FAIL reset_rd_flags: got v=%b e=%b want 0/0", rd_valid, rd_err); else n_pass++;
      n_chk++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %0h want 0", rd_data); else n_pass++;
      @(posedge clk); @(posedge clk); #1 rst = 0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < WORDS; i++) begin
         n_chk++; if (wr_ready !== 1'b1) $display("FAIL fill_ready[%0d]: got %b want 1", i, wr_ready); else n_pass++;
         cyc(0, 1, 32'h100 + i, 0, 0, 0);
         n_chk++; if (level !== LW'(i+1)) $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i+1); else n_pass++;
         n_chk++; if (full !== (i == WORDS-1)) $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == WORDS-1); else n_pass++;
      end
      n_chk++; if (wr_ready !== 1'b0) $display("FAIL full_wr_ready: got %b want 0", wr_ready); else n_pass++;
      cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
      n_chk++; if (level !== LW'(12) || full !== 1'b1) $display("FAIL extra_word: got level=%0d full=%b want 12/1", level, full); else n_pass++;
   endtask

   task automatic test_read();
      cyc(0, 0, 0, 1, 1, 0);
      repeat (LAT-1) idle();
      n_chk++; if (rd_valid !== 1'b1 || rd_err !== 1'b0) $display("FAIL read_b1a0_flags: got v=%b e=%b want 1/0", rd_valid, rd_err); else n_pass++;
      n_chk++; if (rd_data !== 32'h104) $display("FAIL read_b1a0_data: got %0h want 104", rd_data); else n_pass++;
      idle();
      n_chk++; if (rd_valid !== 1'b0 || rd_data !== 32'h104) $display("FAIL read_hold: got v=%b d=%0h want 0/104", rd_valid, rd_data); else n_pass++;
      cyc(0, 0, 0, 1, 2, 3);
      repeat (LAT-1) idle();
      n_chk++; if (rd_data !== 32'h10B) $display("FAIL read_last_word: got %0h want 10b", rd_data); else n_pass++;
      cyc(0, 0, 0, 1, 0, 0);
      repeat (LAT-1) idle();
      n_chk++; if (rd_data !== 32'h100) $display("FAIL read_first_word: got %0h want 100", rd_data); else n_pass++;
   endtask

   task automatic test_out_of_range();
      for (int k = 0; k < LAT+1; k++) begin
         if (k == 0) cyc(0, 0, 0, 1, 3, 0);
         else if (k == 1) cyc(0, 0, 0, 1, 0, 5);
         else idle();
         if (k >= LAT-1) begin
            n_chk++;
            if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== '0)
               $display("FAIL oor[%0d]: got v=%b e=%b d=%0h want 1/1/0", k, rd_valid, rd_err, rd_data);
            else n_pass++;
         end
      end
      idle();
      n_chk++; if (rd_valid !== 1'b0) $display("FAIL oor_single_pulse: got %b want 0", rd_valid); else n_pass++;
   endtask

   task automatic test_rw_same();
      cyc(1, 0, 0, 0, 0, 0);
      n_chk++; if (level !== '0 || full !== 1'b0 || wr_ready !== 1'b1) $display("FAIL restart_state: got l=%0d f=%b r=%b want 0/0/1", level, full, wr_ready); else n_pass++;
      cyc(0, 1, 32'hAAAA, 1, 0, 0);
      repeat (LAT-1) idle();
      n_chk++; if (rd_data !== 32'h100) $display("FAIL rw_same_old: got %0h want 100", rd_data); else n_pass++;
      cyc(0, 0, 0, 1, 0, 0);
      repeat (LAT-1) idle();
      n_chk++; if (rd_data !== 32'hAAAA) $display("FAIL rw_same_new: got %0h want aaaa", rd_data); else n_pass++;
   endtask

   task automatic test_restart();
      for (int i = 1; i <= 4; i++) cyc(0, 1, 32'h200 + i, 0, 0, 0);
      n_chk++; if (level !== LW'(5)) $display("FAIL pre_restart_level: got %0d want 5", level); else n_pass++;
      cyc(1, 1, 32'h0BAD, 0, 0, 0);
      n_chk++; if (level !== '0) $display("FAIL restart_level: got %0d want 0", level); else n_pass++;
      cyc(0, 1, 32'h300, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      repeat (LAT-1) idle();
      n_chk++; if (rd_data !== 32'h300) $display("FAIL restart_next_word: got %0h want 300", rd_data); else n_pass++;
      cyc(0, 0, 0, 1, 1, 1);
      repeat (LAT-1) idle();
      n_chk++; if (rd_data !== 32'h105) $display("FAIL restart_retained: got %0h want 105", rd_data); else n_pass++;
      cyc(0, 0, 0, 1, 0, 1);
      repeat (LAT-1) idle();
      n_chk++; if (rd_data !== 32'h201) $display("FAIL restart_dropped: got %0h want 201", rd_data); else n_pass++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 40) == 0, ($urandom % 4) != 0, $urandom, $urandom % 2,
             $urandom % 4, $urandom % 6);
         n_chk++;
         if (level !== LW'(lvl) || full !== (lvl == WORDS) || wr_ready !== (lvl != WORDS)) begin
            errs++; if (errs < 8) $display("FAIL rand_status[%0d]: got l=%0d f=%b r=%b want l=%0d", i, level, full, wr_ready, lvl);
         end else n_pass++;
         n_chk++;
         if (rd_valid !== exp_v || (exp_v && rd_err !== exp_e) || (exp_k && rd_data !== exp_d)) begin
            errs++; if (errs < 8) $display("FAIL rand_read[%0d]: got v=%b e=%b d=%0h want v=%b e=%b d=%0h", i, rd_valid, rd_err, rd_data, exp_v, exp_e, exp_d);
         end else n_pass++;
      end
   endtask

   task automatic test_rst_mid();
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 32'h400 + i, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 2);
      n_chk++; if (level !== LW'(6)) $display("FAIL pre_rst_level: got %0d want 6", level); else n_pass++;
      rst = 1; rd_en = 0; model_reset();
      #1;
      n_chk++; if (level !== '0 || full !== 1'b0 || wr_ready !== 1'b1) $display("FAIL rst_mid_status: got l=%0d f=%b r=%b want 0/0/1", level, full, wr_ready); else n_pass++;
      n_chk++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== '0) $display("FAIL rst_mid_read: got v=%b e=%b d=%0h want 0/0/0", rd_valid, rd_err, rd_data); else n_pass++;
      @(posedge clk); cnum++; #1 rst = 0;
      idle(); idle();
      n_chk++; if (level !== '0 || rd_valid !== 1'b0) $display("FAIL post_rst: got l=%0d v=%b want 0/0", level, rd_valid); else n_pass++;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cnum = 0;
      test_reset();
      test_fill();
      test_read();
      test_out_of_range();
      test_rw_same();
      test_restart();
      test_random();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
